// File: rtl/clus_ofc_err_encoder.sv
// clus_ofc_err_encoder: debounced, sticky TLK link-error report source
// One report per live period, frozen onto tlk_err_bus with a timed strobe.
module clus_ofc_err_encoder #(
  parameter int NLINK       = 18,
  parameter int MIN_ERR_CYC = 4,
  parameter int HOLD_CYC    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_live,
  input  logic [NLINK-1:0] tlk_err_raw,
  input  logic [NLINK-1:0] link_mask,
  input  logic             rpt_req,
  output logic [NLINK-1:0] tlk_err_bus,
  output logic             got_tlk_err,
  output logic [4:0]       err_count,
  output logic             busy
);

  localparam int CW = $clog2(MIN_ERR_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(MIN_ERR_CYC);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYC);

  typedef enum logic [1:0] {
    IDLE,
    LIVE,
    REPORT,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt     [NLINK];
  logic [CW-1:0]    cnt_nxt [NLINK];
  logic [NLINK-1:0] sticky;
  logic [NLINK-1:0] sticky_nxt;
  logic [NLINK-1:0] snap;
  logic [4:0]       snap_cnt;
  logic [HW-1:0]    hold;

  // Next debounce counters/sticky bits for a LIVE edge, and the snapshot
  // that would be frozen if a report were taken on this same edge.
  always_comb begin
    sticky_nxt = sticky;
    for (int i = 0; i < NLINK; i++) begin
      cnt_nxt[i] = '0;
      if (tlk_err_raw[i])
        cnt_nxt[i] = (cnt[i] == CMAX) ? CMAX : cnt[i] + CW'(1);
      if (cnt_nxt[i] == CMAX)
        sticky_nxt[i] = 1'b1;
    end
    snap     = sticky_nxt & ~link_mask;
    snap_cnt = '0;
    for (int i = 0; i < NLINK; i++)
      snap_cnt = snap_cnt + 5'(snap[i]);
  end

  // Live-period FSM with debounce state and registered report outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sticky      <= '0;
      hold        <= '0;
      tlk_err_bus <= '0;
      err_count   <= '0;
      got_tlk_err <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < NLINK; i++)
        cnt[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_live) begin
            state       <= LIVE;
            sticky      <= '0;
            tlk_err_bus <= '0;
            err_count   <= '0;
            for (int i = 0; i < NLINK; i++)
              cnt[i] <= '0;
          end
        end
        LIVE: begin
          if (!in_live) begin
            state <= IDLE;
          end else begin
            sticky <= sticky_nxt;
            for (int i = 0; i < NLINK; i++)
              cnt[i] <= cnt_nxt[i];
            if (rpt_req) begin
              state       <= REPORT;
              tlk_err_bus <= snap;
              err_count   <= snap_cnt;
              got_tlk_err <= 1'b1;
              busy        <= 1'b1;
              hold        <= HW'(1);
            end
          end
        end
        REPORT: begin
          if (!in_live) begin
            state       <= IDLE;
            got_tlk_err <= 1'b0;
            busy        <= 1'b0;
          end else if (hold == HMAX) begin
            state       <= DONE;
            got_tlk_err <= 1'b0;
            busy        <= 1'b0;
          end else begin
            hold <= hold + HW'(1);
          end
        end
        DONE: begin
          if (!in_live)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clus_ofc_err_encoder.sv
// tb_clus_ofc_err_encoder: directed + random checks of the error encoder
// against a run-length / one-report-per-period reference model.
module tb_clus_ofc_err_encoder;

  localparam int NL   = 18;
  localparam int MIN  = 4;
  localparam int HOLD = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_live;
  logic [NL-1:0] raw;
  logic [NL-1:0] mask;
  logic          rpt_req;
  logic [NL-1:0] bus;
  logic          got;
  logic [4:0]    cnt;
  logic          busy;

  always #5 clk = ~clk;

  clus_ofc_err_encoder #(
    .NLINK      (NL),
    .MIN_ERR_CYC(MIN),
    .HOLD_CYC   (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_live    (in_live),
    .tlk_err_raw(raw),
    .link_mask  (mask),
    .rpt_req    (rpt_req),
    .tlk_err_bus(bus),
    .got_tlk_err(got),
    .err_count  (cnt),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  bit            m_period;
  bit            m_done;
  int            m_run [NL];
  int            m_left;
  logic [NL-1:0] m_sticky;
  logic [NL-1:0] m_bus;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_done   = 1'b0;
    m_left   = 0;
    m_bus    = '0;
    m_sticky = '0;
    for (int i = 0; i < NL; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      m_period = 1'b0;
      model_clear();
    end else if (!m_period) begin
      if (in_live) begin
        m_period = 1'b1;
        model_clear();
      end
    end else if (!in_live) begin
      m_period = 1'b0;
      m_left   = 0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        m_run[i] = raw[i] ? m_run[i] + 1 : 0;
        if (m_run[i] >= MIN) m_sticky[i] = 1'b1;
      end
      if (m_left > 0) m_left--;
      if (rpt_req && !m_done) begin
        m_done = 1'b1;
        m_bus  = m_sticky & ~mask;
        m_left = HOLD;
      end
    end
  endtask

  task automatic step(bit rst, bit live, logic [NL-1:0] r,
                      logic [NL-1:0] m, bit req);
    reset   = rst;
    in_live = live;
    raw     = r;
    mask    = m;
    rpt_req = req;
    @(posedge clk);
    model_edge();
    #1;
    chk("bus", 32'(bus), 32'(m_bus));
    chk("got", 32'(got), 32'(m_left > 0));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("cnt", 32'(cnt), 32'($countones(m_bus)));
  endtask

  task automatic hold_raw(int n, logic [NL-1:0] r, logic [NL-1:0] m);
    for (int k = 0; k < n; k++) step(0, 1, r, m, 0);
  endtask

  localparam logic [NL-1:0] L5  = 18'h00020;
  localparam logic [NL-1:0] L3  = 18'h00008;
  localparam logic [NL-1:0] L0H = 18'h20001;
  localparam logic [NL-1:0] ALL = 18'h3FFFF;

  int hi;
  logic [NL-1:0] rr;

  initial begin
    m_period = 1'b0;
    model_clear();

    step(1, 0, '0, '0, 0);
    step(1, 0, '0, '0, 0);
    chk("rst_bus", 32'(bus), 0);
    chk("rst_got", 32'(got), 0);

    step(0, 0, '0, '0, 1);
    step(0, 0, '0, '0, 0);
    chk("req_idle", 32'(got), 0);

    step(0, 1, '0, '0, 0);
    hold_raw(MIN, L5, '0);
    step(0, 1, '0, '0, 1);
    step(0, 1, '0, '0, 0);
    step(0, 1, '0, '0, 0);
    chk("pre_rst_got", 32'(got), 1);
    step(1, 1, '0, '0, 0);
    chk("rst_mid_bus", 32'(bus), 0);
    chk("rst_mid_got", 32'(got), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    step(0, 0, '0, '0, 0);

    step(0, 1, '0, '0, 0);
    hold_raw(3, L5, '0);
    hold_raw(1, '0, '0);
    hold_raw(4, L5, '0);
    step(0, 1, '0, '0, 1);
    chk("deb_bus", 32'(bus), 32'h20);
    chk("deb_cnt", 32'(cnt), 1);
    hi = 1;
    for (int k = 0; k < HOLD + 3; k++) begin
      step(0, 1, '0, '0, 0);
      if (got) hi++;
    end
    chk("strobe_len", hi, HOLD);
    step(0, 0, '0, '0, 0);

    step(0, 1, '0, '0, 0);
    hold_raw(3, L5, '0);
    step(0, 1, '0, '0, 1);
    chk("short_bus", 32'(bus), 0);
    chk("short_cnt", 32'(cnt), 0);
    step(0, 0, '0, '0, 0);

    step(0, 1, '0, '0, 0);
    hold_raw(MIN, L0H, 18'h20000);
    step(0, 1, '0, 18'h20000, 1);
    chk("mask_bus", 32'(bus), 32'h1);
    chk("mask_cnt", 32'(cnt), 1);
    step(0, 0, '0, '0, 0);

    step(0, 1, '0, '0, 0);
    hold_raw(MIN, ALL, '0);
    step(0, 1, '0, '0, 1);
    chk("all_bus", 32'(bus), 32'h3FFFF);
    chk("all_cnt", 32'(cnt), 18);
    hold_raw(HOLD + 2, '0, '0);
    step(0, 1, '0, '0, 1);
    chk("done_req_got", 32'(got), 0);
    chk("done_req_bus", 32'(bus), 32'h3FFFF);
    step(0, 0, '0, '0, 0);
    chk("exit_keep_bus", 32'(bus), 32'h3FFFF);
    step(0, 1, '0, '0, 0);
    chk("reentry_bus", 32'(bus), 0);
    chk("reentry_cnt", 32'(cnt), 0);
    step(0, 0, '0, '0, 0);

    step(0, 1, '0, '0, 0);
    step(0, 1, '0, '0, 1);
    step(0, 0, '0, '0, 0);
    chk("drop_got", 32'(got), 0);
    chk("drop_busy", 32'(busy), 0);
    step(0, 1, '0, '0, 0);
    step(0, 0, '0, '0, 1);
    chk("coinc_got", 32'(got), 0);
    step(0, 0, '0, '0, 0);

    step(0, 1, '0, '0, 0);
    hold_raw(MIN - 1, L3, '0);
    step(0, 1, L3, '0, 1);
    chk("same_edge_bus", 32'(bus), 32'h8);
    step(0, 0, '0, '0, 0);

    rr = '0;
    for (int k = 0; k < 3000; k++) begin
      rr = rr ^ NL'($urandom & $urandom & $urandom);
      step($urandom_range(0, 199) == 0,
           ($urandom_range(0, 39) == 0) ? ~in_live : in_live,
           rr,
           ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0,
           $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clus_ofc_err_encoder.md
# clus_ofc_err_encoder

Cluster-side source of the TLK link-error report carried to the top CDT error decoder. It debounces the raw per-link TLK receiver error flags during a live period and accumulates them as sticky bits. On a report request it freezes the masked 18-bit error word onto `tlk_err_bus` and strobes `got_tlk_err`. It issues at most one report per live period, which matches the decoder's one-shot latch behaviour.

## Interface
Parameters:
- `NLINK`, 18: number of TLK links; bus width.
- `MIN_ERR_CYC`, 4: consecutive raw-error cycles required to set a link's sticky bit (≥1).
- `HOLD_CYC`, 8: cycles `got_tlk_err` stays high per report (≥1).

Ports:
- `clk`, in, 1: system clock. One clock; reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high.
- `in_live`, in, 1: live-period gate, shared with the decoder.
- `tlk_err_raw`, in, NLINK: per-link raw TLK error flags, synchronous to `clk`.
- `link_mask`, in, NLINK: 1 = link excluded from the report.
- `rpt_req`, in, 1: single-cycle report request.
- `tlk_err_bus`, out, NLINK: reported error word (registered).
- `got_tlk_err`, out, 1: report strobe (registered).
- `err_count`, out, 5: popcount of `tlk_err_bus` (registered).
- `busy`, out, 1: high while in REPORT.

## Operation
- Reset values: state IDLE; all debounce counters and sticky bits 0; `tlk_err_bus`=0, `got_tlk_err`=0, `err_count`=0, `busy`=0.
- States: IDLE, LIVE, REPORT, DONE.
- IDLE:
  - `in_live`=1 → LIVE.
  - On that edge, clear counters, sticky bits, `tlk_err_bus` and `err_count`.
  - Raw errors sampled on that edge are ignored.
- LIVE, per link i:
  - raw=1: counter increments, saturating at MIN_ERR_CYC.
  - raw=0: counter clears to 0.
  - Sticky[i] sets on the edge where the counter reaches MIN_ERR_CYC. It stays set until the next LIVE entry.
  - Masked links still accumulate; the mask is applied only at the snapshot.
- LIVE with `rpt_req`=1 → REPORT, and on that edge:
  - `tlk_err_bus` ← sticky_next & ~`link_mask`, where sticky_next includes bits set on this same edge.
  - `err_count` ← popcount of the same value.
  - `got_tlk_err` ← 1, `busy` ← 1.
- REPORT: hold `got_tlk_err`=1 for exactly HOLD_CYC cycles, then → DONE with `got_tlk_err`=0 and `busy`=0.
- DONE: `tlk_err_bus` and `err_count` are retained; `rpt_req` is ignored.
- Exit on `in_live` falling: LIVE, REPORT or DONE with `in_live`=0 → IDLE. `got_tlk_err` and `busy` drop on that edge; the bus is retained until the next LIVE entry.
- `rpt_req` in IDLE, REPORT or DONE is ignored. A report is never queued.
- Simultaneous `in_live`=0 and `rpt_req`=1 in LIVE: the live drop wins; no report is issued.
- `reset` overrides everything, including mid-report: all outputs are 0 on the next edge.

## Timing
- Raw error high for MIN_ERR_CYC consecutive LIVE cycles, starting at edge e → sticky set at edge e+MIN_ERR_CYC−1.
- `rpt_req` sampled at edge t → outputs valid after edge t: `got_tlk_err`=1 for edges t..t+HOLD_CYC−1 and 0 from edge t+HOLD_CYC. The bus is stable for the whole strobe.
- IDLE→LIVE takes 1 cycle after `in_live` rises. The first debounce sample is the next edge.
- No combinational paths input→output.

## Test plan
- Reset mid-REPORT (cycle 3 of 8) → next edge: all outputs 0, state IDLE; `rpt_req` before `in_live` is ignored (`got_tlk_err` stays 0).
- Debounce:
  - Link 5 raw high 3 cycles, low, then high 4 cycles; `rpt_req` → `tlk_err_bus`=0x00020, `err_count`=1, `got_tlk_err` high exactly 8 cycles.
  - Link 5 raw high 3 cycles only → report 0x00000, `err_count`=0.
- Mask: links 0 and 17 debounced, `link_mask`=0x20000 → `tlk_err_bus`=0x00001, `err_count`=1. All 18 links with mask 0 → 0x3FFFF, `err_count`=18.
- One-shot: second `rpt_req` in DONE → no new strobe, bus unchanged. After `in_live` low for 1 cycle and a new live period, the bus clears to 0 on LIVE entry.
- `in_live` drops at REPORT cycle 2 → `got_tlk_err` 0 on that edge, state IDLE. `rpt_req` coincident with the `in_live` drop in LIVE → no strobe.
- Same-edge set: link 3 counter reaches MIN_ERR_CYC on the `rpt_req` edge → bit 3 is set in the report.
